// File: rtl/fifo_pkg.sv
// Shared constants and sizing helper for the single-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEFAULT = 32'sd8;
    localparam int FIFO_DEPTH_DEFAULT = 32'sd8;

    // Ceiling log2, used for pointer and occupancy widths at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 32'sd0;
        remaining = value - 32'sd1;
        while (remaining > 32'sd0) begin
            result    = result + 32'sd1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dff_reg.sv
// WIDTH-bit rising-edge register with load enable and asynchronous active-low clear.
module dff_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, clear immediately when clear_n drops.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO built from dff_reg storage, wrap-bit pointers and pointer-derived status.
// Optional almost_full/almost_empty ports are enabled by defining FIFO_ALMOST_FLAGS_EN.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH_DEFAULT,
    parameter int DEPTH    = FIFO_DEPTH_DEFAULT,
    parameter int AF_LEVEL = DEPTH - 32'sd2,
    parameter int AE_LEVEL = 32'sd2
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      din,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 32'sd1;

    // Elaboration guard on the geometry and threshold parameters.
    if ((WIDTH < 32'sd1) || (DEPTH < 32'sd2) || ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0) ||
        (AF_LEVEL < 32'sd0) || (AE_LEVEL < 32'sd0)) begin : g_bad_param
        $error("sync_fifo: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [PW-1:0]    wptr_r;
    logic [PW-1:0]    rptr_r;
    logic [PW-1:0]    wptr_nxt_s;
    logic [PW-1:0]    rptr_nxt_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             full_s;
    logic             empty_s;
    logic [PW-1:0]    count_s;
    logic [DEPTH-1:0] wr_sel_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_s;

    // Status from the pointer flops only; a write is blocked by full, a read by empty.
    always_comb begin
        empty_s    = (wptr_r == rptr_r);
        full_s     = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
        count_s    = wptr_r - rptr_r;
        wr_acc_s   = wr_en && !full_s;
        rd_acc_s   = rd_en && !empty_s;
        wptr_nxt_s = wptr_r + PW'(1'b1);
        rptr_nxt_s = rptr_r + PW'(1'b1);
    end

    // One-hot write decode of the storage entry addressed by the write pointer.
    always_comb begin
        wr_sel_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_acc_s && (wptr_r[AW-1:0] == AW'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        dff_reg #(.WIDTH(WIDTH)) u_entry (
            .clk     (clk),
            .clear_n (clear_n),
            .en      (wr_sel_s[g]),
            .d       (din),
            .q       (mem_r[g])
        );
    end

    dff_reg #(.WIDTH(PW)) u_wptr (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (wr_acc_s),
        .d       (wptr_nxt_s),
        .q       (wptr_r)
    );

    dff_reg #(.WIDTH(PW)) u_rptr (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (rd_acc_s),
        .d       (rptr_nxt_s),
        .q       (rptr_r)
    );

    // The entry being written this edge is never the one read, so no bypass is needed.
    assign rd_data_s = mem_r[rptr_r[AW-1:0]];

    dff_reg #(.WIDTH(WIDTH)) u_dout (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (rd_acc_s),
        .d       (rd_data_s),
        .q       (dout)
    );

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_s;

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

    assign almost_full  = (count_s >= AF_THRESH);
    assign almost_empty = (count_s <= AE_THRESH);
`endif

endmodule

// File: doc/sync_fifo.md
# sync_fifo

- Parametrised single-clock FIFO for the FIFO2 datapath; next generation of the FIFO storage element.
- Every storage and pointer bit is a clocked flop with asynchronous clear, generalised to WIDTH-bit words and DEPTH entries.
- Adds full/empty/count status, protected read/write handshakes and optional almost-full/almost-empty flags.
- Sits between a producer and a consumer in the same clock domain.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL

Ports:
- clk  input  1  rising-edge clock
- clear_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write request
- din  input  WIDTH  write data
- rd_en  input  1  read request
- dout  output  WIDTH  read data, registered
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
- almost_full  output  1  present only with FIFO_ALMOST_FLAGS_EN
- almost_empty  output  1  present only with FIFO_ALMOST_FLAGS_EN

One clock (clk); reset clear_n is asynchronous, active-low.

## Operation
- Pointers: wptr and rptr are log2(DEPTH)+1 bits wide.
  - The low bits index storage; the MSB is a wrap bit.
  - Both pointers increment modulo 2·DEPTH.
- Status flags:
  - empty = (wptr == rptr).
  - full = low bits equal and MSBs differ.
  - count = wptr − rptr (modulo 2·DEPTH).
- Write: accepted iff wr_en && !full; mem[wptr] ← din, wptr increments.
- Write when full: ignored; no state change, stored data intact.
- Read: accepted iff rd_en && !empty; dout ← mem[rptr], rptr increments.
- Read when empty: ignored; dout holds its last value.
- Simultaneous write and read, neither blocked: both occur; count unchanged.
- Simultaneous on empty: write accepted, read ignored; count → 1.
- Simultaneous on full: read accepted, write ignored; count → DEPTH−1.
- No pass-through: data written in cycle N is readable at the earliest in cycle N+1.

## Timing
- Reset (clear_n low, asynchronous, immediate):
  - wptr = rptr = 0, all storage = 0, dout = 0.
  - empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = 0.
- Reset deassertion is sampled at the next clk edge; the first write may occur on that edge.
- Reset mid-operation: all contents are discarded; behaviour is identical to power-on reset.
- Read latency: dout is valid on the clk edge that accepts rd_en, i.e. one cycle after the request is presented.
- Flag update timing:
  - full, empty, count and the almost flags are registered-derived.
  - They update on the same edge as the pointer change, with no combinational path from wr_en/rd_en.
- Wrap-around: after 2·DEPTH accepted writes, wptr returns to 0; flags remain correct across wraps.

## Configuration
- Macro FIFO_ALMOST_FLAGS_EN defined:
  - almost_full and almost_empty ports exist.
  - Both are computed from count against AF_LEVEL and AE_LEVEL, updating on the same edge as count.
- Macro not defined:
  - Both ports and their logic are absent.
  - AF_LEVEL and AE_LEVEL are accepted but unused.
  - All other behaviour is identical.

## Structure
- Shared package fifo_pkg holds:
  - default WIDTH and DEPTH constants;
  - a clog2 helper function for pointer and count widths.
- Sub-module dff_reg:
  - WIDTH-bit rising-edge register with enable and asynchronous active-low clear.
  - Instantiated for each storage entry, both pointers and dout.
- The top level contains only pointer arithmetic, write decode and flag logic.

## Test plan
- Reset, then 8 writes 0x01..0x08 (DEPTH=8) -> full=1 after 8th edge, count=8; a 9th write of 0xFF is ignored; reading 8 times returns 0x01..0x08 in order, then empty=1.
- Read on empty after reset -> dout stays 0x00, count stays 0, rptr unchanged.
- Fill to 8, then rd_en=wr_en=1 with din=0xAA -> read returns 0x01, count=7, 0xAA not stored.
- Steady stream of concurrent read/write at count=4 for 20 cycles (pointers wrap) -> count stays 4, data order preserved.
- Assert clear_n low mid-burst at count=5 -> empty=1, count=0, dout=0 immediately without a clock edge; next write/read returns the new data.
- With FIFO_ALMOST_FLAGS_EN, AF_LEVEL=6, AE_LEVEL=2:
  - almost_full rises on the edge count reaches 6;
  - almost_empty falls on the edge count reaches 3.
